// File: rtl/dds_multitone_if.sv
// rtl/dds_multitone_if.sv - shadow-register write port for dds_multitone
interface dds_multitone_if #(
   parameter int pFR_W = 34,
   parameter int pPH_W = 15,
   parameter int pCH_W = 1
);
   logic             iwr_valid;
   logic             owr_ready;
   logic [pCH_W-1:0] iwr_chan;
   logic [pFR_W-1:0] iwr_freq;
   logic [pPH_W-1:0] iwr_phase;
   logic             owr_err;

   modport master (
      output iwr_valid, iwr_chan, iwr_freq, iwr_phase,
      input  owr_ready, owr_err
   );

   modport slave (
      input  iwr_valid, iwr_chan, iwr_freq, iwr_phase,
      output owr_ready, owr_err
   );
endinterface

// File: rtl/dds_multitone.sv
// rtl/dds_multitone.sv - multi-tone phase-continuous DDS with coherent hopping and summed sin/cos
// Optional macro DDS_DITHER_EN: LFSR dither added below the phase truncation point.
module dds_multitone #(
   parameter int  pFR_W  = 34,
   parameter int  pPH_W  = 15,
   parameter int  pDDS_W = 14,
   parameter int  pCHANS = 2,
   localparam int pCH_W  = (pCHANS > 1) ? $clog2(pCHANS) : 1,
   localparam int pSUM_W = pDDS_W + pCH_W
) (
   input  logic                     iclk,
   input  logic                     ireset,
   input  logic                     iclkena,
   dds_multitone_if.slave           wr,
   input  logic                     iupdate,
   input  logic                     isync,
   output logic signed [pSUM_W-1:0] ocos_sum,
   output logic signed [pSUM_W-1:0] osin_sum,
   output logic                     oval
);
   localparam int pQ    = 2 ** (pPH_W - 2);
   localparam int pA    = 2 ** (pDDS_W - 1) - 1;
   localparam int pLO_W = pFR_W - pPH_W;

   function automatic logic [pDDS_W-2:0] quarter_sin(input int k);
      real x;
      x = real'(pA) * $sin(6.283185307179586 * real'(k) / real'(pQ * 4));
      return (pDDS_W-1)'($rtoi(x + 0.5));
   endfunction

   // Quarter-wave table includes the pQ endpoint so quadrant folding never needs a special case.
   function automatic logic [pPH_W-2:0] rom_idx(input logic [pPH_W-1:0] p);
      logic [pPH_W-2:0] k;
      k = {1'b0, p[pPH_W-3:0]};
      return p[pPH_W-2] ? (pPH_W-1)'(pQ) - k : k;
   endfunction

   logic [pDDS_W-2:0] rom [pQ+1];

   genvar gk;
   generate
      for (gk = 0; gk <= pQ; gk++) begin : g_rom
         localparam logic [pDDS_W-2:0] V = quarter_sin(gk);
         assign rom[gk] = V;
      end
   endgenerate

   logic [pFR_W-1:0]          acc       [pCHANS];
   logic [pFR_W-1:0]          sh_freq   [pCHANS];
   logic [pFR_W-1:0]          act_freq  [pCHANS];
   logic [pPH_W-1:0]          sh_phase  [pCHANS];
   logic [pPH_W-1:0]          act_phase [pCHANS];
   logic [pPH_W-1:0]          ph_trunc  [pCHANS];
   logic [pPH_W-1:0]          ph        [pCHANS];
   logic [pDDS_W-2:0]         sin_mag   [pCHANS];
   logic [pDDS_W-2:0]         cos_mag   [pCHANS];
   logic                      sin_neg   [pCHANS];
   logic                      cos_neg   [pCHANS];
   logic signed [pDDS_W-1:0]  sin_smp   [pCHANS];
   logic signed [pDDS_W-1:0]  cos_smp   [pCHANS];
   logic signed [pSUM_W-1:0]  sin_total;
   logic signed [pSUM_W-1:0]  cos_total;
   logic [4:0]                vld_sr;
   logic                      wr_hit;

   assign wr.owr_ready = ~ireset & iclkena;
   assign wr_hit       = wr.iwr_valid & wr.owr_ready;
   assign oval         = vld_sr[4];

`ifdef DDS_DITHER_EN
   logic [31:0]  lfsr;
   logic [pLO_W:0] lo_sum [pCHANS];

   always_ff @(posedge iclk) begin
      if (ireset)
         lfsr <= 32'h1;
      else if (iclkena)
         lfsr <= {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
   end

   always_comb begin
      for (int c = 0; c < pCHANS; c++) begin
         lo_sum[c]   = {1'b0, acc[c][pLO_W-1:0]} + {1'b0, lfsr[pLO_W-1:0]};
         ph_trunc[c] = acc[c][pFR_W-1 -: pPH_W] + pPH_W'(lo_sum[c][pLO_W]);
      end
   end
`else
   always_comb begin
      for (int c = 0; c < pCHANS; c++)
         ph_trunc[c] = acc[c][pFR_W-1 -: pPH_W];
   end
`endif

   always_comb begin
      sin_total = '0;
      cos_total = '0;
      for (int c = 0; c < pCHANS; c++) begin
         sin_total = sin_total + pSUM_W'(sin_smp[c]);
         cos_total = cos_total + pSUM_W'(cos_smp[c]);
      end
   end

   always_ff @(posedge iclk) begin
      if (ireset) begin
         for (int c = 0; c < pCHANS; c++) begin
            acc[c]       <= '0;
            sh_freq[c]   <= '0;
            act_freq[c]  <= '0;
            sh_phase[c]  <= '0;
            act_phase[c] <= '0;
            ph[c]        <= '0;
            sin_mag[c]   <= '0;
            cos_mag[c]   <= '0;
            sin_neg[c]   <= 1'b0;
            cos_neg[c]   <= 1'b0;
            sin_smp[c]   <= '0;
            cos_smp[c]   <= '0;
         end
         osin_sum   <= '0;
         ocos_sum   <= '0;
         vld_sr     <= '0;
         wr.owr_err <= 1'b0;
      end else if (iclkena) begin
         wr.owr_err <= wr_hit && (int'(wr.iwr_chan) >= pCHANS);
         // Commit reads shadow before this cycle's write lands, so a same-cycle write waits.
         for (int c = 0; c < pCHANS; c++) begin
            if (wr_hit && int'(wr.iwr_chan) == c) begin
               sh_freq[c]  <= wr.iwr_freq;
               sh_phase[c] <= wr.iwr_phase;
            end
            if (iupdate) begin
               act_freq[c]  <= sh_freq[c];
               act_phase[c] <= sh_phase[c];
            end
            acc[c]     <= (iupdate && isync) ? '0 : acc[c] + act_freq[c];
            ph[c]      <= ph_trunc[c] + act_phase[c];
            sin_mag[c] <= rom[rom_idx(ph[c])];
            cos_mag[c] <= rom[rom_idx(ph[c] + pPH_W'(pQ))];
            sin_neg[c] <= ph[c][pPH_W-1];
            cos_neg[c] <= ph[c][pPH_W-1] ^ ph[c][pPH_W-2];
            sin_smp[c] <= sin_neg[c] ? -$signed({1'b0, sin_mag[c]}) : $signed({1'b0, sin_mag[c]});
            cos_smp[c] <= cos_neg[c] ? -$signed({1'b0, cos_mag[c]}) : $signed({1'b0, cos_mag[c]});
         end
         osin_sum <= sin_total;
         ocos_sum <= cos_total;
         vld_sr   <= {vld_sr[3:0], 1'b1};
      end else begin
         wr.owr_err <= 1'b0;
      end
   end
endmodule

// File: tb/tb_dds_multitone.sv
// tb/tb_dds_multitone.sv - directed self-checking bench for dds_multitone
module tb_dds_multitone;
   logic clk = 1'b0;
   logic rst, ena, upd, syn;
   always #5 clk = ~clk;

   dds_multitone_if #(.pFR_W(34), .pPH_W(15), .pCH_W(1)) wr_if ();
   dds_multitone_if #(.pFR_W(34), .pPH_W(15), .pCH_W(2)) wr3_if ();

   logic signed [14:0] cos_sum, sin_sum;
   logic signed [15:0] cos3, sin3;
   logic               val, val3;

   dds_multitone #(.pFR_W(34), .pPH_W(15), .pDDS_W(14), .pCHANS(2)) dut (
      .iclk(clk), .ireset(rst), .iclkena(ena), .wr(wr_if), .iupdate(upd), .isync(syn),
      .ocos_sum(cos_sum), .osin_sum(sin_sum), .oval(val)
   );

   dds_multitone #(.pFR_W(34), .pPH_W(15), .pDDS_W(14), .pCHANS(3)) dut3 (
      .iclk(clk), .ireset(rst), .iclkena(ena), .wr(wr3_if), .iupdate(upd), .isync(syn),
      .ocos_sum(cos3), .osin_sum(sin3), .oval(val3)
   );

   int n_pass  = 0;
   int n_total = 0;

   int s2 [4] = '{0, 8191, 0, -8191};
   int c2 [4] = '{16382, 8191, 0, 8191};
   int s4 [8] = '{0, 0, 0, 0, 0, 5056, -5792, -15758};
   int c4 [8] = '{0, 0, 0, 0, 0, -7567, -13983, -3135};

   task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; ena = 1'b1; upd = 1'b0; syn = 1'b0;
      wr_if.iwr_valid = 1'b0; wr_if.iwr_chan = '0; wr_if.iwr_freq = '0; wr_if.iwr_phase = '0;
      wr3_if.iwr_valid = 1'b0; wr3_if.iwr_chan = '0; wr3_if.iwr_freq = '0; wr3_if.iwr_phase = '0;
      @(negedge clk);
      repeat (3) cyc();
      check("rst_cos", cos_sum, 0);
      check("rst_sin", sin_sum, 0);
      check("rst_val", val, 0);
      check("rst_err", wr_if.owr_err, 0);
      check("rst_ready", wr_if.owr_ready, 0);

      rst = 1'b0;
      repeat (4) cyc();
      check("val_4th", val, 0);
      cyc();
      check("val_5th", val, 1);
      check("val3_5th", val3, 1);
      check("idle_cos", cos_sum, 16382);
      check("idle_cos3", cos3, 24573);

      // ch0 quarter-turn per cycle, ch1 static at phase 0
      wr_if.iwr_valid = 1'b1; wr_if.iwr_chan = 1'b0;
      wr_if.iwr_freq = 34'h1_0000_0000; wr_if.iwr_phase = 15'd0;
      check("ready", wr_if.owr_ready, 1);
      cyc();
      wr_if.iwr_valid = 1'b0;
      check("no_err", wr_if.owr_err, 0);
      upd = 1'b1; syn = 1'b1;
      cyc();
      upd = 1'b0; syn = 1'b0;
      repeat (3) cyc();
      for (int n = 0; n < 8; n++) begin
         cyc();
         check($sformatf("t2_sin%0d", n), sin_sum, s2[n % 4]);
         check($sformatf("t2_cos%0d", n), cos_sum, c2[n % 4]);
      end

      // clock enable low: writes/updates ignored, outputs frozen on sample 7
      ena = 1'b0;
      wr_if.iwr_valid = 1'b1; wr_if.iwr_chan = 1'b1;
      wr_if.iwr_freq = 34'h0_4000_0000; wr_if.iwr_phase = 15'd123;
      upd = 1'b1; syn = 1'b1;
      for (int n = 0; n < 3; n++) begin
         cyc();
         check($sformatf("hold_sin%0d", n), sin_sum, s2[3]);
         check($sformatf("hold_cos%0d", n), cos_sum, c2[3]);
         check("hold_ready", wr_if.owr_ready, 0);
      end
      ena = 1'b1; wr_if.iwr_valid = 1'b0; upd = 1'b0; syn = 1'b0;
      for (int n = 8; n < 12; n++) begin
         cyc();
         check($sformatf("resume_sin%0d", n), sin_sum, s2[n % 4]);
         check($sformatf("resume_cos%0d", n), cos_sum, c2[n % 4]);
      end

      // ch1 same speed, half a turn ahead: tones cancel
      wr_if.iwr_valid = 1'b1; wr_if.iwr_chan = 1'b1;
      wr_if.iwr_freq = 34'h1_0000_0000; wr_if.iwr_phase = 15'h4000;
      cyc();
      wr_if.iwr_valid = 1'b0;
      upd = 1'b1; syn = 1'b1;
      cyc();
      upd = 1'b0; syn = 1'b0;
      repeat (3) cyc();
      for (int n = 0; n < 4; n++) begin
         cyc();
         check($sformatf("t3_sin%0d", n), sin_sum, 0);
         check($sformatf("t3_cos%0d", n), cos_sum, 0);
      end

      // write + update in the same cycle: old freq kept, second update applies it
      wr_if.iwr_valid = 1'b1; wr_if.iwr_chan = 1'b1;
      wr_if.iwr_freq = 34'h0_4000_0000; wr_if.iwr_phase = 15'h4000;
      upd = 1'b1;
      cyc();
      wr_if.iwr_valid = 1'b0; upd = 1'b0;
      check("t4_same_sin4", sin_sum, 0);
      check("t4_same_cos4", cos_sum, 0);
      for (int n = 5; n < 8; n++) begin
         cyc();
         check($sformatf("t4_same_sin%0d", n), sin_sum, 0);
         check($sformatf("t4_same_cos%0d", n), cos_sum, 0);
      end
      upd = 1'b1;
      cyc();
      upd = 1'b0;
      check("t4_hop_sin8", sin_sum, s4[0]);
      check("t4_hop_cos8", cos_sum, c4[0]);
      for (int k = 1; k < 8; k++) begin
         cyc();
         check($sformatf("t4_hop_sin%0d", k + 8), sin_sum, s4[k]);
         check($sformatf("t4_hop_cos%0d", k + 8), cos_sum, c4[k]);
      end

      // out-of-range channel on the 3-tone instance
      wr3_if.iwr_valid = 1'b1; wr3_if.iwr_chan = 2'd3;
      wr3_if.iwr_freq = 34'h1_0000_0000; wr3_if.iwr_phase = 15'h2000;
      cyc();
      wr3_if.iwr_valid = 1'b0;
      check("err_pulse", wr3_if.owr_err, 1);
      cyc();
      check("err_clear", wr3_if.owr_err, 0);
      wr3_if.iwr_valid = 1'b1; wr3_if.iwr_chan = 2'd2;
      wr3_if.iwr_freq = '0; wr3_if.iwr_phase = '0;
      cyc();
      wr3_if.iwr_valid = 1'b0;
      check("err_inrange", wr3_if.owr_err, 0);
      upd = 1'b1;
      cyc();
      upd = 1'b0;
      repeat (5) cyc();
      check("err_nochg_cos", cos3, 24573);
      check("err_nochg_sin", sin3, 0);

      check("pre_rst_val", val, 1);
      rst = 1'b1;
      cyc();
      check("mid_rst_cos", cos_sum, 0);
      check("mid_rst_sin", sin_sum, 0);
      check("mid_rst_val", val, 0);
      rst = 1'b0;
      cyc();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
